updown_counter_n: RTL and testbench

Parametrised synchronous up/down counter: the N-bit successor to the 4-bit S169 counter part. It keeps parallel load, the P/T enable pair and the active-low ripple carry, so multiple instances cascade exactly as the S169 chain does. It adds a programmable terminal value (modulus), a registered wrap pulse and an optional saturating mode. It is used for microcode/address counters and timers in the CADR datapath where 4-bit slices were previously chained.

---
 rtl/cadr_cnt_pkg.sv | 9 +
 rtl/updown_counter_tc.sv | 19 +
 rtl/updown_counter_n.sv | 77 +++++++
 tb/tb_updown_counter_n.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cadr_cnt_pkg.sv
// Shared constants for the CADR up/down counter family.
package cadr_cnt_pkg;

    localparam logic CNT_UP = 1'b1;
    localparam logic CNT_DN = 1'b0;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/updown_counter_tc.sv
// Terminal-count detect: end-of-range flag and S169-style active-low carry/borrow.
module updown_counter_tc
    import cadr_cnt_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] cnt,
    input  logic [WIDTH-1:0] max,
    input  logic             up_dn,
    input  logic             enb_t_n,
    output logic             at_end,
    output logic             co_n
);

    // Counting up, anything at or above max (a load can overshoot) is terminal.
    assign at_end = (up_dn == CNT_UP) ? (cnt >= max) : (cnt == '0);
    assign co_n   = ~(at_end & ~enb_t_n);

endmodule

// File: rtl/updown_counter_n.sv
// N-bit cascadable up/down counter with programmable terminal value and wrap pulse.
// Define UDCNT_SAT_EN to add the sat_n port and saturating end-of-range behaviour.
module updown_counter_n
    import cadr_cnt_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_MAX = '1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i,
    input  logic             load_n,
    input  logic [WIDTH-1:0] limit,
    input  logic             limit_ld_n,
    input  logic             enb_p_n,
    input  logic             enb_t_n,
    input  logic             up_dn,
`ifdef UDCNT_SAT_EN
    input  logic             sat_n,
`endif
    output logic [WIDTH-1:0] o,
    output logic             co_n,
    output logic             wrap
);

    logic [WIDTH-1:0] max;
    logic [WIDTH-1:0] o_nxt;
    logic             wrap_nxt;
    logic             at_end;
    logic             sat;

`ifdef UDCNT_SAT_EN
    assign sat = ~sat_n;
`else
    assign sat = 1'b0;
`endif

    updown_counter_tc #(.WIDTH(WIDTH)) u_tc (
        .cnt     (o),
        .max     (max),
        .up_dn   (up_dn),
        .enb_t_n (enb_t_n),
        .at_end  (at_end),
        .co_n    (co_n)
    );

    always_comb begin
        o_nxt    = o;
        wrap_nxt = 1'b0;
        if (!load_n) begin
            o_nxt = i;
        end else if (!enb_p_n && !enb_t_n) begin
            if (!at_end) begin
                o_nxt = (up_dn == CNT_UP) ? o + 1'b1 : o - 1'b1;
            end else if (sat) begin
                o_nxt = (up_dn == CNT_UP) ? max : '0;
            end else begin
                o_nxt    = (up_dn == CNT_UP) ? '0 : max;
                wrap_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o    <= '0;
            max  <= RESET_MAX;
            wrap <= 1'b0;
        end else begin
            o    <= o_nxt;
            wrap <= wrap_nxt;
            // A count on the same edge already used the old max via at_end.
            if (!limit_ld_n) max <= limit;
        end
    end

endmodule

// File: tb/tb_updown_counter_n.sv
// Randomised and directed bench for updown_counter_n against a behavioural model.
module tb_updown_counter_n;
    import cadr_cnt_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] i, limit;
    logic         load_n, limit_ld_n, enb_p_n, enb_t_n, up_dn, sat_n;
    logic [W-1:0] o;
    logic         co_n, wrap;

    logic [7:0]   c_i;
    logic         c_load_n, c_enb_n, c_up;
    logic [3:0]   lo_o, hi_o;
    logic         lo_co_n, hi_co_n, lo_wrap, hi_wrap;

    int n_tests = 0;
    int n_fail  = 0;
    int m_o, m_max, m_wrap, c_val;

    always #5 clk = ~clk;

    updown_counter_n #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .i(i), .load_n(load_n), .limit(limit),
        .limit_ld_n(limit_ld_n), .enb_p_n(enb_p_n), .enb_t_n(enb_t_n), .up_dn(up_dn),
`ifdef UDCNT_SAT_EN
        .sat_n(sat_n),
`endif
        .o(o), .co_n(co_n), .wrap(wrap)
    );

    updown_counter_n #(.WIDTH(4)) u_lo (
        .clk(clk), .reset_n(reset_n), .i(c_i[3:0]), .load_n(c_load_n), .limit(4'hF),
        .limit_ld_n(1'b1), .enb_p_n(c_enb_n), .enb_t_n(c_enb_n), .up_dn(c_up),
`ifdef UDCNT_SAT_EN
        .sat_n(1'b1),
`endif
        .o(lo_o), .co_n(lo_co_n), .wrap(lo_wrap)
    );

    updown_counter_n #(.WIDTH(4)) u_hi (
        .clk(clk), .reset_n(reset_n), .i(c_i[7:4]), .load_n(c_load_n), .limit(4'hF),
        .limit_ld_n(1'b1), .enb_p_n(c_enb_n), .enb_t_n(lo_co_n), .up_dn(c_up),
`ifdef UDCNT_SAT_EN
        .sat_n(1'b1),
`endif
        .o(hi_o), .co_n(hi_co_n), .wrap(hi_wrap)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit sat_on();
`ifdef UDCNT_SAT_EN
        return !sat_n;
`else
        return 1'b0;
`endif
    endfunction

    // Carry is low when the T enable is active and the current direction has reached its end.
    function automatic int exp_co();
        bit term;
        term = up_dn ? (m_o >= m_max) : (m_o == 0);
        return (!enb_t_n && term) ? 0 : 1;
    endfunction

    task automatic model_reset();
        m_o = 0; m_max = 255; m_wrap = 0; c_val = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".o"},    o,    m_o);
        check({tag, ".wrap"}, wrap, m_wrap);
        check({tag, ".co_n"}, co_n, exp_co());
        check({tag, ".cas"},  {hi_o, lo_o}, c_val);
    endtask

    task automatic step(input string tag);
        int nmax;
        @(posedge clk);
        nmax   = limit_ld_n ? m_max : int'(limit);
        m_wrap = 0;
        if (!load_n) begin
            m_o = i;
        end else if (!enb_p_n && !enb_t_n) begin
            if (up_dn) begin
                if (m_o < m_max)   m_o = m_o + 1;
                else if (sat_on()) m_o = m_max;
                else begin m_o = 0; m_wrap = 1; end
            end else begin
                if (m_o > 0)       m_o = m_o - 1;
                else if (sat_on()) m_o = 0;
                else begin m_o = m_max; m_wrap = 1; end
            end
        end
        m_max = nmax;
        if (!c_load_n)     c_val = c_i;
        else if (!c_enb_n) c_val = c_up ? (c_val + 1) % 256 : (c_val + 255) % 256;
        #1;
        check_all(tag);
    endtask

    initial begin
        reset_n = 1'b0; i = '0; limit = '0; load_n = 1'b1; limit_ld_n = 1'b1;
        enb_p_n = 1'b1; enb_t_n = 1'b1; up_dn = CNT_UP; sat_n = 1'b1;
        c_i = '0; c_load_n = 1'b1; c_enb_n = 1'b1; c_up = CNT_UP;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk) reset_n = 1'b1;

        // Modulus 9 count-up wrap
        limit = 8'd9; limit_ld_n = 1'b0;
        step("ldlim");
        limit_ld_n = 1'b1; enb_p_n = 1'b0; enb_t_n = 1'b0;
        repeat (10) step("mod");

        // Load above max, wrap up, then wrap down
        i = 8'h20; load_n = 1'b0;
        step("ld20");
        load_n = 1'b0; load_n = 1'b1;
        step("upwrap");
        up_dn = CNT_DN;
        step("dnwrap");

        // P disabled holds; carry still reflects terminal; load beats count
        up_dn = CNT_UP; enb_p_n = 1'b1;
        repeat (2) step("hold");
        enb_p_n = 1'b0; i = 8'd3; load_n = 1'b0;
        step("ldprio");
        load_n = 1'b1;

        // Cascade across the nibble boundary
        c_i = 8'h0F; c_load_n = 1'b0;
        step("casld");
        c_load_n = 1'b1; c_enb_n = 1'b0; c_up = CNT_UP;
        step("casup");
        c_up = CNT_DN;
        step("casdn");
        c_enb_n = 1'b1;

        // Mid-count async reset with O=0x37 and WRAP high
        limit = 8'h37; limit_ld_n = 1'b0; i = 8'd0; load_n = 1'b0;
        step("prerst");
        limit_ld_n = 1'b1; load_n = 1'b1; up_dn = CNT_DN;
        step("at37");
        #2 reset_n = 1'b0;
        model_reset();
        #1 check_all("asyncrst");
        @(negedge clk) reset_n = 1'b1;
        up_dn = CNT_UP;
        i = 8'hFE; load_n = 1'b0;
        step("ldfe");
        load_n = 1'b1;
        repeat (2) step("fullmax");

`ifdef UDCNT_SAT_EN
        sat_n = 1'b0; limit = 8'd5; limit_ld_n = 1'b0; i = 8'd4; load_n = 1'b0;
        step("satld");
        limit_ld_n = 1'b1; load_n = 1'b1; up_dn = CNT_UP;
        repeat (3) step("satup");
        i = 8'd1; load_n = 1'b0;
        step("satld1");
        load_n = 1'b1; up_dn = CNT_DN;
        repeat (2) step("satdn");
        sat_n = 1'b1;
`endif

        for (int k = 0; k < 400; k++) begin
            load_n     = ($urandom_range(0, 11) != 0);
            i          = W'($urandom);
            limit_ld_n = ($urandom_range(0, 15) != 0);
            limit      = W'($urandom_range(0, 40));
            enb_p_n    = ($urandom_range(0, 4) == 0);
            enb_t_n    = ($urandom_range(0, 4) == 0);
            up_dn      = $urandom_range(0, 1) != 0;
            sat_n      = $urandom_range(0, 2) != 0;
            c_load_n   = ($urandom_range(0, 15) != 0);
            c_i        = 8'($urandom);
            c_enb_n    = ($urandom_range(0, 3) == 0);
            c_up       = $urandom_range(0, 1) != 0;
            #1;
            check("rnd.co_comb", co_n, exp_co());
            step("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
